calc_seq: RTL

CALC_SEQ -- requirements
Module: calc_seq

---
 rtl/calc_pkg.sv | 43 ++++
 rtl/btn_edge.sv | 35 +++
 rtl/calc_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state codes, default timing
// parameters and the registered control-output bundle decoded from state.
package calc_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_LDA  = 3'd1,
        S_B    = 3'd2,
        S_LDB  = 3'd3,
        S_EXEC = 3'd4,
        S_LDR  = 3'd5,
        S_SHOW = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam int EXEC_CYCLES_DEF    = 2;
    localparam int TIMEOUT_CYCLES_DEF = 50_000_000;

    typedef struct packed {
        logic loada;
        logic loadb;
        logic loadr;
        logic select;
        logic busy;
        logic error;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{loada: 1'b1, loadb: 1'b1, loadr: 1'b1,
                                  select: 1'b0, busy: 1'b0, error: 1'b0};

    // Load strobes are active-low; everything else active-high.
    function automatic ctl_t decode_ctl(input state_t st);
        ctl_t c;
        c.loada  = (st != S_LDA);
        c.loadb  = (st != S_LDB);
        c.loadr  = (st != S_LDR);
        c.select = (st == S_SHOW) || (st == S_ERR);
        c.busy   = st inside {S_LDA, S_LDB, S_EXEC, S_LDR};
        c.error  = (st == S_ERR);
        return c;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Raw active-low pushbutton -> one-cycle press pulse; 2-flop sync plus edge flop,
// pulse appears 2 edges after the first low sample; no backpressure.
module btn_edge (
    input  logic CLOCK,
    input  logic RESET,
    input  logic btn_n,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // High only on the synchronised high->low transition, so a held button fires once.
    assign pulse = prev_q & ~sync2_q;

endmodule

// File: rtl/calc_seq.sv
// Two-operand calculator sequencer; outputs are registered one cycle behind STATE, no backpressure.
// Define CALC_SEQ_OVR_LOCK_EN to trap ALU overflow in S_ERR until CLEAR or RESET.
module calc_seq
    import calc_pkg::*;
#(
    parameter int EXEC_CYCLES    = EXEC_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       ENTER,
    input  logic       CLEAR,
    input  logic       ADDSUB,
    input  logic       VALID,
    input  logic       OVR,
    output logic       LOADA,
    output logic       LOADB,
    output logic       LOADR,
    output logic       SELECT,
    output logic       OPSEL,
    output logic       BUSY,
    output logic       REJECT,
    output logic       ERROR,
    output logic [2:0] STATE
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]       EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    logic enter_p;
    logic clear_p;

    btn_edge u_enter_edge (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .btn_n (ENTER),
        .pulse (enter_p)
    );

    btn_edge u_clear_edge (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .btn_n (CLEAR),
        .pulse (clear_p)
    );

    state_t           state_q,    state_d;
    logic [3:0]       exec_cnt_q, exec_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    ctl_t             ctl_q,      ctl_d;
    logic             reject_q,   reject_d;
    logic             opsel_q,    opsel_d;
    state_t           dec_st;

    always_comb begin
        state_d    = state_q;
        reject_d   = 1'b0;
        opsel_d    = opsel_q;
        exec_cnt_d = (state_q == S_EXEC) ? exec_cnt_q + 4'd1 : 4'd0;
        tmo_cnt_d  = (state_q == S_B) ? tmo_cnt_q + 1'b1 : '0;

        if (clear_p) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A: begin
                    if (enter_p) begin
                        if (VALID) state_d  = S_LDA;
                        else       reject_d = 1'b1;
                    end
                end
                S_LDA: state_d = S_B;
                S_B: begin
                    if (enter_p && VALID) begin
                        state_d = S_LDB;
                        opsel_d = ADDSUB;
                    end else begin
                        reject_d = enter_p;
                        // A rejected press does not restart the idle window.
                        if (tmo_cnt_q == TMO_LAST) state_d = S_A;
                    end
                end
                S_LDB:  state_d = S_EXEC;
                S_EXEC: begin
                    if (exec_cnt_q == EXEC_LAST) state_d = S_LDR;
                end
                S_LDR: begin
`ifdef CALC_SEQ_OVR_LOCK_EN
                    state_d = OVR ? S_ERR : S_SHOW;
`else
                    state_d = S_SHOW;
`endif
                end
                S_SHOW: begin
                    if (enter_p) state_d = S_A;
                end
                default: begin
`ifdef CALC_SEQ_OVR_LOCK_EN
                    state_d = state_q;
`else
                    state_d = S_A;
`endif
                end
            endcase
        end
    end

    always_comb begin
        dec_st = state_q;
`ifdef CALC_SEQ_OVR_LOCK_EN
        ctl_d = decode_ctl(dec_st);
`else
        if (state_q == S_ERR) dec_st = S_A;
        ctl_d = decode_ctl(dec_st);
`endif
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_A;
            exec_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            ctl_q      <= CTL_IDLE;
            reject_q   <= 1'b0;
            opsel_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            exec_cnt_q <= exec_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ctl_q      <= ctl_d;
            reject_q   <= reject_d;
            opsel_q    <= opsel_d;
        end
    end

    assign LOADA  = ctl_q.loada;
    assign LOADB  = ctl_q.loadb;
    assign LOADR  = ctl_q.loadr;
    assign SELECT = ctl_q.select;
    assign BUSY   = ctl_q.busy;
    assign OPSEL  = opsel_q;
    assign REJECT = reject_q;
    assign STATE  = state_q;

`ifdef CALC_SEQ_OVR_LOCK_EN
    assign ERROR = ctl_q.error;
`else
    logic unused_cfg;
    assign unused_cfg = ^{OVR, ctl_q.error};
    assign ERROR = 1'b0;
`endif

endmodule
